// File: rtl/apb_param_pkg.sv
// rtl/apb_param_pkg.sv - shared widths, bus types and FSM state encoding for apb_cmd_master
package apb_param_pkg;

   localparam int ADDR = 32;
   localparam int DATA = 32;
   localparam int STRB = DATA / 8;

   typedef logic [ADDR-1:0] ADDR_t;
   typedef logic [DATA-1:0] DATA_t;
   typedef logic [STRB-1:0] STRB_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_RESP   = 2'd3
   } state_t;

endpackage

// File: rtl/apb_cmd_master.sv
// rtl/apb_cmd_master.sv - single-command APB requester; optional ACCESS timeout under APB_CMD_MASTER_TIMEOUT_EN
module apb_cmd_master #(
   parameter int ADDR           = apb_param_pkg::ADDR,
   parameter int DATA           = apb_param_pkg::DATA,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic              PCLK,
   input  logic              PRESETn,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [ADDR-1:0]   cmd_addr,
   input  logic [DATA-1:0]   cmd_wdata,
   input  logic [DATA/8-1:0] cmd_strb,
   input  logic              cmd_write,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA-1:0]   rsp_rdata,
   output logic              rsp_err,
   output logic              PSEL,
   output logic              PENABLE,
   output logic              PWRITE,
   output logic [ADDR-1:0]   PADDR,
   output logic [DATA-1:0]   PWDATA,
   output logic [DATA/8-1:0] PSTRB,
   input  logic              PREADY,
   input  logic              PSLVERR,
   input  logic [DATA-1:0]   PRDATA
);
   import apb_param_pkg::*;

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("apb_cmd_master: TIMEOUT_CYCLES must be at least 1");
   end

   state_t state_q;
   state_t state_d;
   logic   timeout;

`ifdef APB_CMD_MASTER_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] to_cnt;

   // Counts stalled ACCESS cycles; fires on the last allowed one unless PREADY wins.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         to_cnt <= '0;
      end else if (state_q == ST_SETUP) begin
         to_cnt <= '0;
      end else if (state_q == ST_ACCESS && !PREADY) begin
         to_cnt <= to_cnt + CW'(1);
      end
   end

   assign timeout = (state_q == ST_ACCESS) && !PREADY && (to_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:   if (cmd_valid) state_d = ST_SETUP;
         ST_SETUP:  state_d = ST_ACCESS;
         ST_ACCESS: if (PREADY || timeout) state_d = ST_RESP;
         ST_RESP:   if (rsp_ready) state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      cmd_ready = 1'b0;
      PSEL      = 1'b0;
      PENABLE   = 1'b0;
      rsp_valid = 1'b0;
      unique case (state_q)
         ST_IDLE:   cmd_ready = 1'b1;
         ST_SETUP:  PSEL = 1'b1;
         ST_ACCESS: begin
            PSEL    = 1'b1;
            PENABLE = 1'b1;
         end
         ST_RESP:   rsp_valid = 1'b1;
         default:   cmd_ready = 1'b0;
      endcase
   end

   // Bus fields only load at acceptance, so they stay put from SETUP through RESP.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         PADDR     <= '0;
         PWDATA    <= '0;
         PSTRB     <= '0;
         PWRITE    <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         if (state_q == ST_IDLE && cmd_valid) begin
            PADDR  <= cmd_addr;
            PWDATA <= cmd_wdata;
            PSTRB  <= cmd_write ? cmd_strb : '0;
            PWRITE <= cmd_write;
         end
         if (state_q == ST_ACCESS && PREADY) begin
            rsp_err   <= PSLVERR;
            rsp_rdata <= (!PWRITE && !PSLVERR) ? PRDATA : '0;
         end else if (timeout) begin
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
         end
      end
   end

endmodule

// File: tb/tb_apb_cmd_master.sv
// tb/tb_apb_cmd_master.sv - table-driven and randomized bench for apb_cmd_master
module tb_apb_cmd_master;

   localparam int TO = 16;

   logic        PCLK = 1'b0;
   logic        PRESETn;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr, cmd_wdata;
   logic [3:0]  cmd_strb;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [31:0] rsp_rdata;
   logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
   logic [31:0] PADDR, PWDATA, PRDATA;
   logic [3:0]  PSTRB;

   always #5 PCLK = ~PCLK;

   apb_cmd_master #(.ADDR(32), .DATA(32), .TIMEOUT_CYCLES(TO)) dut (
      .PCLK(PCLK), .PRESETn(PRESETn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
      .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_write(cmd_write),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
      .PWDATA(PWDATA), .PSTRB(PSTRB), .PREADY(PREADY), .PSLVERR(PSLVERR), .PRDATA(PRDATA)
   );

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      int          waits;
      logic        slverr;
      logic [31:0] prdata;
      int          hold;
      logic        noise;
      logic [31:0] exp_rdata;
      logic        exp_err;
      int          exp_lat;
   } vec_t;

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   // Expected response from the transfer rules: completer answers after `waits` stalls.
   function automatic vec_t model(input vec_t v);
      vec_t m = v;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
      if (v.waits >= TO) begin
         m.exp_err   = 1'b1;
         m.exp_rdata = 32'h0;
         m.exp_lat   = 2 + TO;
         return m;
      end
`endif
      m.exp_err   = v.slverr;
      m.exp_rdata = (v.wr || v.slverr) ? 32'h0 : v.prdata;
      m.exp_lat   = 3 + v.waits;
      return m;
   endfunction

   task automatic do_reset();
      PRESETn = 1'b0;
      @(negedge PCLK);
      @(negedge PCLK);
      PRESETn = 1'b1;
   endtask

   task automatic xfer(input vec_t v, input string tag);
      int   c, acc, lat;
      bit   setup_ok, acc_ok, hold_ok, got_rsp;
      logic [31:0] r0;
      logic        e0;
      logic [3:0]  exp_strb;
      exp_strb = v.wr ? v.strb : 4'h0;
      @(negedge PCLK);
      chk({tag, "_cmd_ready"}, cmd_ready, 1'b1);
      cmd_valid = 1'b1;
      cmd_addr  = v.addr;
      cmd_wdata = v.wdata;
      cmd_strb  = v.strb;
      cmd_write = v.wr;
      @(posedge PCLK);
      #1;
      if (v.noise) begin
         cmd_addr  = $urandom;
         cmd_wdata = $urandom;
         cmd_strb  = 4'($urandom);
         cmd_write = 1'($urandom);
         rsp_ready = 1'b1;
      end else begin
         cmd_valid = 1'b0;
      end
      c = 0; acc = 0; lat = -1;
      setup_ok = 1'b1; acc_ok = 1'b1; got_rsp = 1'b0;
      while (!got_rsp && c < 400) begin
         @(negedge PCLK);
         c++;
         if (rsp_valid) begin
            got_rsp = 1'b1;
            lat = c;
         end else begin
            if (!(PSEL && PADDR == v.addr && PWRITE == v.wr && PWDATA == v.wdata && PSTRB == exp_strb))
               if (c == 1) setup_ok = 1'b0; else acc_ok = 1'b0;
            if (c == 1) begin
               if (PENABLE) setup_ok = 1'b0;
            end else begin
               if (!PENABLE) acc_ok = 1'b0;
               acc++;
               PREADY  = (acc > v.waits);
               PSLVERR = PREADY && v.slverr;
               PRDATA  = v.prdata;
            end
         end
      end
      PREADY  = 1'b0;
      PSLVERR = 1'b0;
      PRDATA  = $urandom;
      chk({tag, "_latency"}, 64'(lat), 64'(v.exp_lat));
      chk({tag, "_setup"}, setup_ok, 1'b1);
      chk({tag, "_access"}, acc_ok, 1'b1);
      if (!got_rsp) begin
         cmd_valid = 1'b0;
         rsp_ready = 1'b0;
         do_reset();
         return;
      end
      r0 = rsp_rdata;
      e0 = rsp_err;
      chk({tag, "_rdata"}, r0, v.exp_rdata);
      chk({tag, "_err"}, e0, v.exp_err);
      hold_ok = !PSEL && !PENABLE && !cmd_ready;
      rsp_ready = (v.hold == 0);
      for (int i = 0; i < v.hold; i++) begin
         @(negedge PCLK);
         if (!(rsp_valid && rsp_rdata == r0 && rsp_err == e0 && !cmd_ready && !PSEL && !PENABLE))
            hold_ok = 1'b0;
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge PCLK);
      #1;
      rsp_ready = 1'b0;
      chk({tag, "_resp_hold"}, hold_ok, 1'b1);
      @(negedge PCLK);
      chk({tag, "_back_idle"}, {rsp_valid, cmd_ready, PSEL, PENABLE}, 4'b0100);
   endtask

   vec_t tbl[5];
   vec_t v;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      PRESETn = 1'b0;
      cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_strb = '0;
      rsp_ready = 1'b0; PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = '0;

      tbl[0] = '{wr:1'b1, addr:32'h10, wdata:32'hCAFE_F00D, strb:4'hF, waits:0, slverr:1'b0,
                 prdata:32'hDEAD_BEEF, hold:0, noise:1'b0, exp_rdata:32'h0, exp_err:1'b0, exp_lat:3};
      tbl[1] = '{wr:1'b0, addr:32'h20, wdata:32'h0, strb:4'hF, waits:3, slverr:1'b0,
                 prdata:32'h1234_5678, hold:1, noise:1'b0, exp_rdata:32'h1234_5678, exp_err:1'b0, exp_lat:6};
      tbl[2] = '{wr:1'b0, addr:32'h30, wdata:32'h0, strb:4'h0, waits:1, slverr:1'b1,
                 prdata:32'hFFFF_0000, hold:4, noise:1'b0, exp_rdata:32'h0, exp_err:1'b1, exp_lat:4};
      tbl[3] = '{wr:1'b1, addr:32'h44, wdata:32'h0BAD_0BAD, strb:4'h3, waits:2, slverr:1'b1,
                 prdata:32'h7777_7777, hold:2, noise:1'b1, exp_rdata:32'h0, exp_err:1'b1, exp_lat:5};
      tbl[4] = '{wr:1'b0, addr:32'hFFFF_FFFC, wdata:32'h5555_5555, strb:4'hC, waits:0, slverr:1'b0,
                 prdata:32'hA5A5_5A5A, hold:0, noise:1'b1, exp_rdata:32'hA5A5_5A5A, exp_err:1'b0, exp_lat:3};

      #12;
      chk("reset_ctrl", {PSEL, PENABLE, PWRITE, rsp_valid, rsp_err}, 5'b0);
      chk("reset_paddr", PADDR, 32'h0);
      chk("reset_pwdata_pstrb", {PWDATA, PSTRB}, 36'h0);
      chk("reset_rdata", rsp_rdata, 32'h0);
      chk("reset_cmd_ready", cmd_ready, 1'b1);
      @(negedge PCLK);
      PRESETn = 1'b1;

      for (int i = 0; i < 5; i++) xfer(tbl[i], $sformatf("tbl%0d", i));

      for (int i = 0; i < 40; i++) begin
         v.wr     = 1'($urandom);
         v.addr   = $urandom;
         v.wdata  = $urandom;
         v.strb   = 4'($urandom);
         v.waits  = int'($urandom_range(0, 5));
         v.slverr = ($urandom_range(0, 3) == 0);
         v.prdata = $urandom;
         v.hold   = int'($urandom_range(0, 3));
         v.noise  = 1'($urandom);
         xfer(model(v), $sformatf("rnd%0d", i));
      end

      // Stalled completer: times out with the macro, otherwise keeps waiting.
      v = '{wr:1'b0, addr:32'h60, wdata:32'h0, strb:4'h0, waits:120, slverr:1'b0,
            prdata:32'h0F0F_0F0F, hold:1, noise:1'b0, exp_rdata:32'h0, exp_err:1'b0, exp_lat:0};
      xfer(model(v), "stall");
      v.waits = TO - 1;
      xfer(model(v), "just_ready");

      // Reset in the middle of ACCESS aborts the transfer.
      @(negedge PCLK);
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h55; cmd_wdata = 32'h1122_3344; cmd_strb = 4'hF;
      @(posedge PCLK);
      #1;
      cmd_valid = 1'b0;
      @(negedge PCLK);
      @(negedge PCLK);
      @(negedge PCLK);
      chk("pre_reset_access", {PSEL, PENABLE, PWRITE}, 3'b111);
      #2;
      PRESETn = 1'b0;
      #1;
      chk("async_reset_ctrl", {PSEL, PENABLE, PWRITE, rsp_valid, rsp_err}, 5'b0);
      chk("async_reset_bus", {PADDR, PWDATA, PSTRB}, 68'h0);
      chk("async_reset_rdata", rsp_rdata, 32'h0);
      @(negedge PCLK);
      PRESETn = 1'b1;
      @(negedge PCLK);
      chk("post_reset_ready", {cmd_ready, rsp_valid}, 2'b10);
      xfer(tbl[1], "after_reset");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
